// File: rtl/tc_sparse_tile_sched_pkg.sv
// tc_sparse_tile_sched_pkg
//   Shared configuration for the sparse tile scheduler: matrix and tile
//   geometry, derived tile counts, pointer and counter widths, the FSM state
//   encoding and helpers that map tile indices to mask bits and to element
//   offsets.
//   Optional feature macro: TC_SPARSE_SKIP_EN (consumed by the top level).
package tc_sparse_tile_sched_pkg;

  function automatic int iter_count(input int dim, input int tile);
    return dim / tile;
  endfunction

  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  localparam int M      = 16;
  localparam int N      = 16;
  localparam int K      = 16;
  localparam int TILE_M = 4;
  localparam int TILE_N = 4;
  localparam int TILE_K = 4;

  localparam int ITER_M = iter_count(M, TILE_M);
  localparam int ITER_N = iter_count(N, TILE_N);
  localparam int ITER_K = iter_count(K, TILE_K);

  localparam int PTR_W   = 4;
  localparam int CNT_W   = $clog2(ITER_M * ITER_N * ITER_K + 1);
  localparam int IDX_M_W = idx_width(ITER_M);
  localparam int IDX_N_W = idx_width(ITER_N);
  localparam int IDX_K_W = idx_width(ITER_K);
  localparam int A_W     = ITER_M * ITER_K;
  localparam int B_W     = ITER_K * ITER_N;
  localparam int A_IDX_W = idx_width(A_W);
  localparam int B_IDX_W = idx_width(B_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } tc_state_e;

  // A tile (mi,ki) lives at bit mi*ITER_K+ki of a_mask.
  function automatic logic [A_IDX_W-1:0] a_bit(input int mi, input int ki);
    return A_IDX_W'(mi * ITER_K + ki);
  endfunction

  // B tile (ki,ni) lives at bit ki*ITER_N+ni of b_mask.
  function automatic logic [B_IDX_W-1:0] b_bit(input int ki, input int ni);
    return B_IDX_W'(ki * ITER_N + ni);
  endfunction

  function automatic logic [PTR_W-1:0] idx_to_ptr(input int idx, input int tile);
    return PTR_W'(idx * tile);
  endfunction

endpackage

// File: rtl/tc_sparse_tile_sched_iter.sv
// tc_sched_iter
//   Nested tile index counter for the scheduler. Loop order is n outer,
//   m middle, k inner. Also evaluates the current candidate against the
//   latched masks and looks ahead for any hit at a higher k in the same
//   C tile (used to flag the last accumulation beat).
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   clr_i           zero all indices (start of pass)
//   adv_i           step to the next candidate (k inner)
//   adv_tile_i      jump to the last k of the current C tile, then step,
//                   i.e. move straight to k=0 of the next C tile
//   a_mask_i/b_mask_i  latched tile nonzero maps
//   mi_o/ki_o/ni_o  current tile indices
//   hit_o           A(mi,ki) and B(ki,ni) both nonzero
//   hit_higher_o    some k' > ki also hits for this (mi,ni)
//   k_last_o        ki is the last k
//   tile_last_o     (mi,ni) is the final C tile of the pass
module tc_sched_iter
  import tc_sparse_tile_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               adv_i,
  input  logic               adv_tile_i,
  input  logic [A_W-1:0]     a_mask_i,
  input  logic [B_W-1:0]     b_mask_i,
  output logic [IDX_M_W-1:0] mi_o,
  output logic [IDX_K_W-1:0] ki_o,
  output logic [IDX_N_W-1:0] ni_o,
  output logic               hit_o,
  output logic               hit_higher_o,
  output logic               k_last_o,
  output logic               tile_last_o
);

  localparam logic [IDX_M_W-1:0] M_MAX = IDX_M_W'(ITER_M - 1);
  localparam logic [IDX_N_W-1:0] N_MAX = IDX_N_W'(ITER_N - 1);
  localparam logic [IDX_K_W-1:0] K_MAX = IDX_K_W'(ITER_K - 1);

  logic [IDX_M_W-1:0] mi_q, mi_d;
  logic [IDX_K_W-1:0] ki_q, ki_d;
  logic [IDX_N_W-1:0] ni_q, ni_d;
  logic               k_wrap;

  always_comb begin
    mi_d   = mi_q;
    ki_d   = ki_q;
    ni_d   = ni_q;
    k_wrap = adv_tile_i | (ki_q == K_MAX);
    if (clr_i) begin
      mi_d = '0;
      ki_d = '0;
      ni_d = '0;
    end else if (adv_i | adv_tile_i) begin
      if (!k_wrap) begin
        ki_d = ki_q + 1'b1;
      end else begin
        ki_d = '0;
        if (mi_q == M_MAX) begin
          mi_d = '0;
          ni_d = (ni_q == N_MAX) ? '0 : ni_q + 1'b1;
        end else begin
          mi_d = mi_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mi_q <= '0;
      ki_q <= '0;
      ni_q <= '0;
    end else begin
      mi_q <= mi_d;
      ki_q <= ki_d;
      ni_q <= ni_d;
    end
  end

  // Candidate hit and OR of all higher-k hits within the same C tile.
  always_comb begin
    hit_o        = a_mask_i[a_bit(int'(mi_q), int'(ki_q))] &
                   b_mask_i[b_bit(int'(ki_q), int'(ni_q))];
    hit_higher_o = 1'b0;
    for (int k = 0; k < ITER_K; k++) begin
      if (k > int'(ki_q)) begin
        hit_higher_o = hit_higher_o |
                       (a_mask_i[a_bit(int'(mi_q), k)] & b_mask_i[b_bit(k, int'(ni_q))]);
      end
    end
  end

  assign mi_o        = mi_q;
  assign ki_o        = ki_q;
  assign ni_o        = ni_q;
  assign k_last_o    = (ki_q == K_MAX);
  assign tile_last_o = (mi_q == M_MAX) && (ni_q == N_MAX);

endmodule

// File: rtl/tc_sparse_tile_sched.sv
// tc_sparse_tile_sched
//   Sequences one C = A x B pass of the tiled tensor-core datapath, issuing
//   one beat per active (m,k,n) tile triple and skipping zero tile pairs via
//   the A/B nonzero bitmaps. A C tile with no active pair gets a single
//   zero_tile beat so every C tile is still written back.
//   Macro TC_SPARSE_SKIP_EN: when defined the masks are honoured; otherwise
//   the latched masks are all ones (dense sequencing) and the mask ports
//   are unused.
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   start                   begin a pass (only looked at in IDLE)
//   a_mask, b_mask          tile nonzero bitmaps, latched at start
//   issue_ready/issue_valid beat handshake with the datapath
//   ptr_m/ptr_n/ptr_k       element offsets of the current tiles
//   first_k/last_k          clear accumulator / write back C tile
//   zero_tile               C tile has no active pair, write zeros
//   busy, done              pass in progress / one-cycle end pulse
//   beat_cnt                beats accepted in the current/last pass
//   dbg_state               FSM state, for observation only
//
// Handshake: issue_valid rises in ISSUE and every beat output (ptrs,
// first_k, last_k, zero_tile) is held until the cycle in which
// issue_valid & issue_ready are both sampled high on a rising edge; that
// edge is the transfer. issue_valid never drops without a transfer except
// on reset.
module tc_sparse_tile_sched
  import tc_sparse_tile_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [A_W-1:0]   a_mask,
  input  logic [B_W-1:0]   b_mask,
  input  logic             issue_ready,
  output logic             issue_valid,
  output logic [PTR_W-1:0] ptr_m,
  output logic [PTR_W-1:0] ptr_n,
  output logic [PTR_W-1:0] ptr_k,
  output logic             first_k,
  output logic             last_k,
  output logic             zero_tile,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] beat_cnt,
  output tc_state_e        dbg_state
);

  tc_state_e        state_q, state_d;
  logic [A_W-1:0]   a_q, a_d;
  logic [B_W-1:0]   b_q, b_d;
  logic             tile_open_q, tile_open_d;
  logic [PTR_W-1:0] ptr_m_q, ptr_m_d, ptr_n_q, ptr_n_d, ptr_k_q, ptr_k_d;
  logic             first_q, first_d, last_q, last_d, zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic               it_clr, it_adv, it_adv_tile;
  logic [IDX_M_W-1:0] mi;
  logic [IDX_K_W-1:0] ki;
  logic [IDX_N_W-1:0] ni;
  logic               hit, hit_higher, k_last, tile_last;

`ifdef TC_SPARSE_SKIP_EN
  logic [A_W-1:0] a_load;
  logic [B_W-1:0] b_load;
  assign a_load = a_mask;
  assign b_load = b_mask;
`else
  logic [A_W-1:0] a_load;
  logic [B_W-1:0] b_load;
  logic           unused_masks;
  assign a_load       = '1;
  assign b_load       = '1;
  assign unused_masks = ^{a_mask, b_mask};
`endif

  tc_sched_iter u_iter (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (it_clr),
    .adv_i        (it_adv),
    .adv_tile_i   (it_adv_tile),
    .a_mask_i     (a_q),
    .b_mask_i     (b_q),
    .mi_o         (mi),
    .ki_o         (ki),
    .ni_o         (ni),
    .hit_o        (hit),
    .hit_higher_o (hit_higher),
    .k_last_o     (k_last),
    .tile_last_o  (tile_last)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    tile_open_d = tile_open_q;
    ptr_m_d     = ptr_m_q;
    ptr_n_d     = ptr_n_q;
    ptr_k_d     = ptr_k_q;
    first_d     = first_q;
    last_d      = last_q;
    zero_d      = zero_q;
    cnt_d       = cnt_q;
    it_clr      = 1'b0;
    it_adv      = 1'b0;
    it_adv_tile = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d         = a_load;
          b_d         = b_load;
          cnt_d       = '0;
          tile_open_d = 1'b0;
          it_clr      = 1'b1;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hit) begin
          ptr_m_d = idx_to_ptr(int'(mi), TILE_M);
          ptr_n_d = idx_to_ptr(int'(ni), TILE_N);
          ptr_k_d = idx_to_ptr(int'(ki), TILE_K);
          first_d = ~tile_open_q;
          last_d  = ~hit_higher;
          zero_d  = 1'b0;
          state_d = ST_ISSUE;
        end else if (k_last && !tile_open_q) begin
          // Whole C tile empty: one zero_tile beat so it is still written.
          ptr_m_d = idx_to_ptr(int'(mi), TILE_M);
          ptr_n_d = idx_to_ptr(int'(ni), TILE_N);
          ptr_k_d = '0;
          first_d = 1'b1;
          last_d  = 1'b1;
          zero_d  = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          it_adv = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (issue_ready) begin
          cnt_d       = cnt_q + 1'b1;
          tile_open_d = ~last_q;
          if (last_q && tile_last) begin
            state_d = ST_DONE;
          end else begin
            // After the last beat of a C tile the remaining k are known
            // misses, so go straight to the next C tile.
            it_adv_tile = last_q;
            it_adv      = ~last_q;
            state_d     = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      tile_open_q <= 1'b0;
      ptr_m_q     <= '0;
      ptr_n_q     <= '0;
      ptr_k_q     <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      zero_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tile_open_q <= tile_open_d;
      ptr_m_q     <= ptr_m_d;
      ptr_n_q     <= ptr_n_d;
      ptr_k_q     <= ptr_k_d;
      first_q     <= first_d;
      last_q      <= last_d;
      zero_q      <= zero_d;
      cnt_q       <= cnt_d;
    end
  end

  assign issue_valid = (state_q == ST_ISSUE);
  assign busy        = (state_q == ST_SCAN) || (state_q == ST_ISSUE);
  assign done        = (state_q == ST_DONE);
  assign ptr_m       = ptr_m_q;
  assign ptr_n       = ptr_n_q;
  assign ptr_k       = ptr_k_q;
  assign first_k     = first_q;
  assign last_k      = last_q;
  assign zero_tile   = zero_q;
  assign beat_cnt    = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_tc_sparse_tile_sched.sv
module tb_tc_sparse_tile_sched;
  import tc_sparse_tile_sched_pkg::*;

  localparam int W = 3 * PTR_W + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             start;
  logic [A_W-1:0]   a_mask;
  logic [B_W-1:0]   b_mask;
  logic             issue_ready;
  logic             issue_valid;
  logic [PTR_W-1:0] ptr_m, ptr_n, ptr_k;
  logic             first_k, last_k, zero_tile, busy, done;
  logic [CNT_W-1:0] beat_cnt;
  tc_state_e        dbg_state;

  tc_sparse_tile_sched dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a_mask      (a_mask),
    .b_mask      (b_mask),
    .issue_ready (issue_ready),
    .issue_valid (issue_valid),
    .ptr_m       (ptr_m),
    .ptr_n       (ptr_n),
    .ptr_k       (ptr_k),
    .first_k     (first_k),
    .last_k      (last_k),
    .zero_tile   (zero_tile),
    .busy        (busy),
    .done        (done),
    .beat_cnt    (beat_cnt),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int           exp_total;
  int           exp_lat;
  bit           done_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_beat(input int m, input int n, input int k,
                                             input bit f, input bit l, input bit z);
    logic [PTR_W-1:0] pm, pn, pk;
    pm = PTR_W'(m * TILE_M);
    pn = PTR_W'(n * TILE_N);
    pk = PTR_W'(k * TILE_K);
    return {pm, pn, pk, f, l, z};
  endfunction

  // Reference model: walk C tiles in n,m order, list the k that pair two
  // nonzero tiles, and emit one beat per active k (or one zero beat).
  task automatic build_expected(input logic [A_W-1:0] a_in, input logic [B_W-1:0] b_in);
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    a = a_in;
    b = b_in;
`ifndef TC_SPARSE_SKIP_EN
    a = '1;
    b = '1;
`endif
    exp_q.delete();
    exp_total = 0;
    for (int n = 0; n < ITER_N; n++) begin
      for (int m = 0; m < ITER_M; m++) begin
        int ks[$];
        for (int k = 0; k < ITER_K; k++)
          if (a[m * ITER_K + k] && b[k * ITER_N + n]) ks.push_back(k);
        if (n == 0 && m == 0)
          exp_lat = 2 + ((ks.size() == 0) ? (ITER_K - 1) : ks[0]);
        if (ks.size() == 0) begin
          exp_q.push_back(pack_beat(m, n, 0, 1'b1, 1'b1, 1'b1));
          exp_total++;
        end else begin
          for (int i = 0; i < ks.size(); i++) begin
            exp_q.push_back(pack_beat(m, n, ks[i], i == 0, i == ks.size() - 1, 1'b0));
            exp_total++;
          end
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] held;
  bit           hold_valid = 1'b0;
  bit           prev_done = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] cur;
    cur = {ptr_m, ptr_n, ptr_k, first_k, last_k, zero_tile};
    if (reset) begin
      hold_valid = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (issue_valid && hold_valid) check("beat_stable", cur, held);
      if (issue_valid && issue_ready) begin
        if (exp_q.size() == 0) check("extra_beat", cur, '0 - 1);
        else check("beat", cur, exp_q.pop_front());
        hold_valid = 1'b0;
      end else if (issue_valid) begin
        hold_valid = 1'b1;
        held       = cur;
      end else begin
        hold_valid = 1'b0;
      end
      if (done) begin
        check("done_pulse_width", prev_done, 0);
        check("done_beat_cnt", beat_cnt, exp_total);
        check("done_beats_left", exp_q.size(), 0);
        check("done_busy", busy, 0);
        done_seen = 1'b1;
      end
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  // mode 0: ready=1, 1: random ready, 2: ready low 5 cycles, 3: start pulsed while busy
  task automatic drive_start(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    build_expected(a, b);
    done_seen = 1'b0;
    @(posedge clk); #1;
    a_mask = a;
    b_mask = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_pass(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input int mode);
    bit seen_v;
    int cyc;
    seen_v = 1'b0;
    drive_start(a, b);
    for (cyc = 1; cyc <= 2000 && !done_seen; cyc++) begin
      if (!seen_v && issue_valid) begin
        seen_v = 1'b1;
        check("first_valid_latency", cyc, exp_lat);
      end
      case (mode)
        1:       issue_ready = ($urandom_range(0, 3) != 0);
        2:       issue_ready = !(cyc >= 10 && cyc < 15);
        default: issue_ready = 1'b1;
      endcase
      start  = (mode == 3) && (cyc == 6 || cyc == 7) && busy;
      a_mask = A_W'($urandom);
      b_mask = B_W'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!done_seen) check("pass_timeout", 0, 1);
    check("idle_busy", busy, 0);
    check("idle_valid", issue_valid, 0);
    check("idle_beat_cnt_hold", beat_cnt, exp_total);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, issue_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_flags"}, {first_k, last_k, zero_tile}, 0);
    check({tag, "_ptrs"}, {ptr_m, ptr_n, ptr_k}, 0);
    check({tag, "_beat_cnt"}, beat_cnt, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    a_mask      = '0;
    b_mask      = '0;
    issue_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    run_pass('1, '1, 0);                      // dense
    run_pass('0, '1, 0);                      // all A tiles zero
    run_pass(A_W'(16'h0001), '1, 0);          // only A(0,0) nonzero
    run_pass('1, '1, 2);                      // ready stall mid-tile

    // Reset in the middle of a pass.
    drive_start('1, '1);
    issue_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("midpass_reset");
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    run_pass('1, '1, 0);

    run_pass(A_W'(16'h0001), '1, 3);          // start while busy ignored

    for (int r = 0; r < 6; r++) begin
      logic [A_W-1:0] ra;
      logic [B_W-1:0] rb;
      ra = A_W'($urandom) & A_W'($urandom);
      rb = B_W'($urandom) | B_W'($urandom);
      run_pass(ra, rb, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
